agex_muldiv_unit: RTL and testbench
===================================

AGEX_MULDIV_UNIT -- requirements
Module: agex_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; legal values 8..64, even.
REQ-002 SHALL have parameter REGNOBITS, default 5, destination-register tag width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operation offered by the AGEX stage.
REQ-006 SHALL have port in_ready, output, 1, unit can accept; transfer occurs when in_valid && in_ready at a clk edge.
REQ-007 SHALL have port in_op, input, 3, funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have ports in_a and in_b, input, XLEN each, rs1 and rs2 values.
REQ-009 SHALL have port in_rd, input, REGNOBITS, destination tag carried through to the output.
REQ-010 SHALL have port flush, input, 1, kills any in-flight or held operation.
REQ-011 SHALL have port out_valid, output, 1, result presented.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts; the result retires when out_valid && out_ready.
REQ-013 SHALL have ports out_result (XLEN) and out_rd (REGNOBITS), outputs, result and tag.
REQ-014 SHALL have port busy, output, 1, high in BUSY or DONE; used by DE as a stall source.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in BUSY and DONE it SHALL be 0, so only one operation is in flight.
REQ-017 On accept of a normal op the FSM SHALL go to BUSY and run an iterative radix-2 engine for exactly XLEN cycles, then go to DONE; out_valid rises XLEN+1 cycles after the accept edge.
REQ-018 MUL SHALL return the low XLEN bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits, with operands treated as signed/signed, signed/unsigned and unsigned/unsigned respectively.
REQ-019 DIV and REM SHALL be signed, with the quotient truncated toward zero and the remainder taking the dividend's sign; DIVU and REMU SHALL be unsigned.
REQ-020 For divide by zero, DIV/DIVU SHALL return all-ones and REM/REMU SHALL return in_a; the FSM SHALL go directly IDLE->DONE, so out_valid rises 1 cycle after accept.
REQ-021 For signed overflow (in_a = MIN, in_b = -1), DIV SHALL return MIN and REM SHALL return 0, with the same 1-cycle latency.
REQ-022 Operands, op and rd SHALL be captured at accept; later changes on the in_* ports SHALL have no effect.
REQ-023 In DONE, out_result and out_rd SHALL hold stable until out_ready; on retire the FSM SHALL go to IDLE and out_valid SHALL drop the next cycle.
REQ-024 The unit SHALL NOT accept a new op in the cycle its result retires (in_ready is 0 in DONE).
REQ-025 flush SHALL send the FSM to IDLE at the next edge from any state and drop out_valid without retiring.
REQ-026 flush SHALL take priority over simultaneous in_valid in IDLE (no accept) and over out_ready in DONE.
REQ-027 The iteration counter SHALL be sized clog2(XLEN)+1 bits and SHALL NOT wrap within an operation.
REQ-028 out_valid SHALL be 1 only in DONE; out_result and out_rd SHALL be 0 in IDLE and BUSY.

Reset
REQ-029 While reset is low, asynchronously: FSM = IDLE, counter = 0, all datapath registers = 0, out_valid = 0, busy = 0, out_result = 0, out_rd = 0; in_ready SHALL be 1 once reset is released.
REQ-030 Assertion of reset mid-operation SHALL abandon the operation; no result is ever presented for it.

Verification
REQ-031 XLEN=32, MUL a=0xFFFFFFFF, b=2, rd=7, out_ready=1 -> out_valid at cycle 33, out_result=0xFFFFFFFE, out_rd=7.
REQ-032 MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-033 DIV a=-7, b=2 -> -3; REM a=-7, b=2 -> -1; DIVU a=7, b=0 -> 0xFFFFFFFF at cycle 1; REM a=0x80000000, b=-1 -> 0 at cycle 1.
REQ-034 Backpressure: out_ready=0 for 10 cycles after DONE -> out_valid, out_result and out_rd stable, in_ready=0; out_ready=1 -> one retire, then in_ready=1.
REQ-035 flush at cycle 10 of a DIV -> IDLE next cycle, no out_valid; a new op accepted afterwards completes with correct results.
REQ-036 reset pulsed low mid-BUSY, asynchronous to clk -> outputs cleared immediately without waiting for a clk edge; random signed/unsigned ops checked against a reference model for XLEN=8, 32 and 64.

Source files
------------

// File: rtl/agex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the AGEX stage (RV M-extension funct3 set).
// One operation in flight; divide-by-zero and signed overflow bypass the engine.
module agex_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int REGNOBITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [XLEN-1:0]      in_a,
    input  logic [XLEN-1:0]      in_b,
    input  logic [REGNOBITS-1:0] in_rd,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [REGNOBITS-1:0] out_rd,
    output logic                 busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          count;
    logic [XLEN-1:0]        acc_hi, acc_lo, mcand, result_q;
    logic [2:0]             op_q;
    logic [REGNOBITS-1:0]   rd_q;
    logic                   neg_q;

    logic                   accept, special, last_step;
    logic                   sign_a, sign_b, a_neg, b_neg, neg_load, div_zero, overflow;
    logic [XLEN-1:0]        a_mag, b_mag, special_res;

    logic [XLEN:0]          sum, shifted;
    logic                   ge;
    logic [XLEN-1:0]        div_sub, next_hi, next_lo, div_val, div_res, mul_res, final_res;
    logic [2*XLEN-1:0]      prod, prod_fix;

    // Operands are reduced to magnitudes so one unsigned engine serves every op.
    always_comb begin
        sign_a      = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
        sign_b      = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
        a_neg       = sign_a & in_a[XLEN-1];
        b_neg       = sign_b & in_b[XLEN-1];
        a_mag       = a_neg ? -in_a : in_a;
        b_mag       = b_neg ? -in_b : in_b;
        neg_load    = (in_op[2] & in_op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero    = in_op[2] && (in_b == '0);
        overflow    = in_op[2] && !in_op[0] && (in_a == MIN_VAL) && (in_b == '1);
        special     = div_zero || overflow;
        special_res = div_zero ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : MIN_VAL);
    end

    // One shift-add or restoring-subtract step; acc_hi is partial product or remainder.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        shifted = {acc_hi, acc_lo[XLEN-1]};
        ge      = shifted >= {1'b0, mcand};
        div_sub = shifted[XLEN-1:0] - mcand;
        if (op_q[2]) begin
            next_hi = ge ? div_sub : shifted[XLEN-1:0];
            next_lo = {acc_lo[XLEN-2:0], ge};
        end else begin
            next_hi = sum[XLEN:1];
            next_lo = {sum[0], acc_lo[XLEN-1:1]};
        end
        prod      = {next_hi, next_lo};
        prod_fix  = neg_q ? -prod : prod;
        mul_res   = (op_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        div_val   = op_q[1] ? next_hi : next_lo;
        div_res   = neg_q ? -div_val : div_val;
        final_res = op_q[2] ? div_res : mul_res;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept     = 1'b1;
                    state_next = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (count == LAST) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The final engine step is folded into result formatting so the result lands with DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mcand    <= '0;
            result_q <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
        end else if (accept) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            mcand    <= b_mag;
            result_q <= special ? special_res : '0;
            op_q     <= in_op;
            rd_q     <= in_rd;
            neg_q    <= neg_load;
        end else if (state == BUSY && !flush) begin
            acc_hi <= next_hi;
            acc_lo <= next_lo;
            count  <= count + CW'(1);
            if (last_step) result_q <= final_res;
        end
    end

    assign busy       = (state != IDLE);
    assign out_valid  = (state == DONE);
    assign out_result = out_valid ? result_q : '0;
    assign out_rd     = out_valid ? rd_q : '0;

endmodule

// File: tb/tb_agex_muldiv_unit.sv
// Directed and model-checked bench for agex_muldiv_unit at XLEN=32: latency, results,
// backpressure, flush and asynchronous reset behaviour.
module tb_agex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;

    agex_muldiv_unit #(.XLEN(32), .REGNOBITS(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Waits for IDLE, offers one op, returns #1 after the accept edge with inputs scrambled.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("readyTimeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = ~op;
        in_a     = ~a;
        in_b     = a ^ 32'h5A5A_5A5A;
        in_rd    = ~rd;
    endtask

    // Latency counts clock edges from the accept edge (inclusive) until out_valid is seen.
    task automatic waitResult(output int lat, output logic [31:0] res, output logic [4:0] rdo);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = out_result;
        rdo = out_rd;
    endtask

    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        ua  = {32'b0, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    initial begin
        int          lat;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        ok;
        logic        seen;

        vecs = '{
            '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7,  32'hFFFF_FFFE, 33},
            '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33},
            '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33},
            '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF, 33},
            '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 33},
            '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 33},
            '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 33},
            '{3'd5, 32'd100,       32'd7,         5'd8,  32'd14,        33},
            '{3'd7, 32'd100,       32'd7,         5'd9,  32'd2,         33},
            '{3'd5, 32'd7,         32'd0,         5'd10, 32'hFFFF_FFFF, 1},
            '{3'd7, 32'd7,         32'd0,         5'd11, 32'd7,         1},
            '{3'd4, 32'd0,         32'd0,         5'd12, 32'hFFFF_FFFF, 1},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1},
            '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1}
        };

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        #12;
        checkOutput("rstOutValid", 64'(out_valid), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstResult", 64'(out_result), 64'd0);
        checkOutput("rstRd", 64'(out_rd), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rstInReady", 64'(in_ready), 64'd1);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            waitResult(lat, res, rdo);
            checkOutput($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
            checkOutput($sformatf("vec%0d_rd", i), 64'(rdo), 64'(vecs[i].rd));
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end
        @(posedge clk);
        #1;
        checkOutput("retireDrop", 64'(out_valid), 64'd0);

        // Backpressure: result and tag must hold while the consumer stalls.
        out_ready = 1'b0;
        applyStimulus(3'd0, 32'd3, 32'd5, 5'd3);
        waitResult(lat, res, rdo);
        checkOutput("bpResult", 64'(res), 64'd15);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (!out_valid || out_result != 32'd15 || out_rd != 5'd3 || in_ready || !busy) ok = 1'b0;
        end
        checkOutput("bpHold", 64'(ok), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bpRetire", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("bpReadyAfter", 64'(in_ready), 64'd1);

        // Flush on cycle 10 of a divide, then a fresh op must still complete.
        applyStimulus(3'd4, 32'd100, 32'd7, 5'd20);
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flushBusy", 64'(busy), 64'd0);
        checkOutput("flushValid", 64'(out_valid), 64'd0);
        checkOutput("flushReady", 64'(in_ready), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checkOutput("flushNoResult", 64'(seen), 64'd0);
        applyStimulus(3'd5, 32'd100, 32'd7, 5'd21);
        waitResult(lat, res, rdo);
        checkOutput("postFlushResult", 64'(res), 64'd14);
        checkOutput("postFlushRd", 64'(rdo), 64'd21);

        // Flush beats a simultaneous offer in IDLE.
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_a     = 32'd9;
        in_b     = 32'd9;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flushIdleNoAccept", 64'(busy), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;

        // Flush beats out_ready in DONE.
        out_ready = 1'b0;
        applyStimulus(3'd5, 32'd9, 32'd0, 5'd22);
        waitResult(lat, res, rdo);
        checkOutput("flushDoneLatency", 64'(lat), 64'd1);
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flushDoneValid", 64'(out_valid), 64'd0);
        @(negedge clk);
        flush = 1'b0;

        // Reset mid-BUSY, between clock edges.
        applyStimulus(3'd0, 32'd11, 32'd13, 5'd23);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("asyncRstBusy", 64'(busy), 64'd0);
        checkOutput("asyncRstValid", 64'(out_valid), 64'd0);
        #2;
        reset = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checkOutput("asyncRstNoResult", 64'(seen), 64'd0);

        // Reset while a result is held clears the outputs at once.
        out_ready = 1'b0;
        applyStimulus(3'd0, 32'hFFFF_FFFF, 32'd2, 5'd7);
        waitResult(lat, res, rdo);
        checkOutput("heldBeforeRst", 64'(res), 64'hFFFF_FFFE);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("heldRstValid", 64'(out_valid), 64'd0);
        checkOutput("heldRstResult", 64'(out_result), 64'd0);
        checkOutput("heldRstRd", 64'(out_rd), 64'd0);
        #2;
        reset     = 1'b1;
        out_ready = 1'b1;

        // Random operations against the reference model.
        for (int r = 0; r < 12; r++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            logic        spec;
            op   = 3'($urandom_range(0, 7));
            a    = (r == 3) ? 32'h8000_0000 : $urandom;
            b    = ($urandom_range(0, 3) == 0) ? 32'd0 : ((r == 3) ? 32'hFFFF_FFFF : $urandom);
            spec = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            applyStimulus(op, a, b, 5'(r));
            waitResult(lat, res, rdo);
            checkOutput($sformatf("rand%0d_op%0d_result", r, op), 64'(res), 64'(refModel(op, a, b)));
            checkOutput($sformatf("rand%0d_latency", r), 64'(lat), spec ? 64'd1 : 64'd33);
        end

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
